spi_proto_wrap: RTL and testbench
=================================

Name: spi_proto_wrap

Overview:
- Sits between the SPI slave byte core and the SPI-attached function blocks, such as the message mailbox and register bridges.
- Converts raw MOSI bytes plus chip-select into the shared pw_* write stream: data, command flag, strobe and end-of-transaction.
- Arbitrates which client owns the MISO response path and buffers the granted client's response bytes in a small TX FIFO that the SPI core drains.

Parameters:
- N_CLIENTS, 2, number of pw_* clients (1..8).
- TX_DEPTH, 16, response FIFO depth in bytes (power of 2, >= 2).
- FILL_BYTE, 8'h00, MISO byte returned when the TX FIFO is empty.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- sc_csn  in  1  SPI chip-select level, already synchronised to clk, active low
- sc_rx_data  in  8  MOSI byte from SPI core
- sc_rx_stb  in  1  one-cycle pulse; sc_rx_data valid
- sc_tx_data  out  8  MISO byte offered to SPI core
- sc_tx_ack  in  1  one-cycle pulse; core latched sc_tx_data and wants the next byte
- pw_wdata  out  8  broadcast MOSI byte
- pw_wcmd  out  1  qualifies pw_wstb: byte is first of transaction
- pw_wstb  out  1  one-cycle byte strobe
- pw_end  out  1  one-cycle pulse: transaction ended
- pw_req  in  N_CLIENTS  per-client response-path request
- pw_gnt  out  N_CLIENTS  one-hot (or zero) grant
- pw_rdata  in  8*N_CLIENTS  per-client response byte, client i at [8i+7:8i]
- pw_rstb  in  N_CLIENTS  per-client response byte strobe
- tx_ovf  out  1  sticky: response byte dropped because FIFO was full
- irq  out  1  response data pending

Behaviour:
- Reset (async assert, released synchronously):
  - pw_wdata = 0; pw_wcmd, pw_wstb, pw_end, pw_gnt, tx_ovf, irq = 0.
  - FIFO empty; sc_tx_data = FILL_BYTE.
  - internal csn_d = 1; first_pending = 0.
- Write path:
  - csn falling edge (csn_d = 1, sc_csn = 0) sets first_pending.
  - sc_rx_stb registers: pw_wdata <= sc_rx_data, pw_wstb <= 1, pw_wcmd <= first_pending, and clears first_pending. Latency is exactly 1 cycle.
  - sc_rx_stb while sc_csn high is ignored.
  - pw_wcmd is 0 whenever pw_wstb is 0.
- End:
  - csn rising edge gives pw_end = 1 for one cycle, 1 cycle after the edge.
  - If the final sc_rx_stb and the rising edge fall in the same cycle, pw_wstb and pw_end assert in the same cycle.
  - A falling edge in the same cycle that pw_end is emitted is legal; the next stb is still flagged cmd.
- Arbiter states:
  - IDLE (pw_gnt = 0): when sc_csn = 1, the FIFO is empty and any pw_req bit is set, grant the lowest-index requester next cycle and move to GRANTED.
  - GRANTED: the grant is held while that pw_req bit stays 1. When it drops, return to IDLE, but only once sc_csn = 1 and the FIFO is empty.
  - While waiting to return, no new grant is issued and pw_gnt stays on the old client.
  - Grant never changes during an SPI transaction.
- Response FIFO:
  - Pushes pw_rdata[granted] when pw_rstb[granted] = 1 and a grant is active.
  - pw_rstb from non-granted clients is ignored.
  - sc_tx_data = FIFO head when non-empty, else FILL_BYTE. This is combinational from registers, with no latency.
  - sc_tx_ack pops when non-empty and is a no-op when empty.
  - Full and push without pop: byte dropped, tx_ovf <= 1.
  - Full with push and pop in the same cycle: both happen, no drop.
  - Empty with push and ack in the same cycle: the ack consumes FILL_BYTE and the pushed byte is stored.
  - Pointers are log2(TX_DEPTH)+1 bits wide; the extra MSB distinguishes full from empty on wrap.
- tx_ovf clears on the next csn falling edge. A push-drop in that same cycle wins, so tx_ovf stays 1.
- irq is a register equal to (FIFO non-empty) | (|(pw_req & pw_gnt)).

Test Plan:
1. Transaction 0x10,0xAA,0x55 then csn high -> three pw_wstb pulses, each 1 cycle after sc_rx_stb. pw_wcmd = 1 only on 0x10. pw_end pulses once, 1 cycle after the csn rise.
2. pw_req = 2'b11 while idle -> pw_gnt = 2'b01. Client 0 drops req during a transaction -> grant held until csn high and FIFO drained, then pw_gnt = 2'b10.
3. Granted client pushes 0xDE,0xAD; client 1 also strobes 0x77 -> SPI core reads 0xDE, 0xAD, then FILL_BYTE 0x00. The 0x77 never appears.
4. Push TX_DEPTH+1 bytes (0x00..0x10) with no acks -> reads return 0x00..0x0F and tx_ovf = 1. Next csn fall -> tx_ovf = 0.
5. FIFO full with push and ack in the same cycle -> no drop, count unchanged, tx_ovf stays 0. Pointer wrap across 3*TX_DEPTH bytes with interleaved acks -> data order preserved.
6. Assert rst mid-transaction with the FIFO holding 3 bytes -> outputs clear immediately without a clock. After release, the next stb is not flagged cmd until a fresh csn fall.

Source files
------------

// File: rtl/spi_proto_wrap_if.sv
// spi_proto_wrap_if: SPI byte-core and pw_* client signals bundled for the protocol wrapper.
interface spi_proto_wrap_if #(
    parameter int N_CLIENTS = 2
);
    logic                   sc_csn;
    logic [7:0]             sc_rx_data;
    logic                   sc_rx_stb;
    logic [7:0]             sc_tx_data;
    logic                   sc_tx_ack;
    logic [7:0]             pw_wdata;
    logic                   pw_wcmd;
    logic                   pw_wstb;
    logic                   pw_end;
    logic [N_CLIENTS-1:0]   pw_req;
    logic [N_CLIENTS-1:0]   pw_gnt;
    logic [8*N_CLIENTS-1:0] pw_rdata;
    logic [N_CLIENTS-1:0]   pw_rstb;
    logic                   tx_ovf;
    logic                   irq;

    modport slave (
        input  sc_csn, sc_rx_data, sc_rx_stb, sc_tx_ack, pw_req, pw_rdata, pw_rstb,
        output sc_tx_data, pw_wdata, pw_wcmd, pw_wstb, pw_end, pw_gnt, tx_ovf, irq
    );

    modport master (
        output sc_csn, sc_rx_data, sc_rx_stb, sc_tx_ack, pw_req, pw_rdata, pw_rstb,
        input  sc_tx_data, pw_wdata, pw_wcmd, pw_wstb, pw_end, pw_gnt, tx_ovf, irq
    );
endinterface

// File: rtl/spi_proto_wrap.sv
// spi_proto_wrap: MOSI bytes to pw_* write stream, response-path arbiter and MISO TX FIFO.
module spi_proto_wrap #(
    parameter int         N_CLIENTS = 2,
    parameter int         TX_DEPTH  = 16,
    parameter logic [7:0] FILL_BYTE = 8'h00
) (
    input logic             clk,
    input logic             rst,
    spi_proto_wrap_if.slave bus
);
    localparam int AW = $clog2(TX_DEPTH);
    localparam int GW = N_CLIENTS > 1 ? $clog2(N_CLIENTS) : 1;

    typedef enum logic {S_IDLE, S_GRANTED} state_t;

    state_t               r_state, w_state_nx;
    logic                 r_csn_d, r_first, r_wstb, r_wcmd, r_end, r_ovf, r_irq;
    logic [7:0]           r_wdata;
    logic [N_CLIENTS-1:0] r_gnt, w_gnt_nx;
    logic [GW-1:0]        r_gidx, w_gidx_nx;
    logic [AW:0]          r_wp, r_rp;
    logic [7:0]           r_mem [TX_DEPTH];
    logic                 w_fall, w_rise, w_first, w_stb_ok;
    logic                 w_empty, w_full, w_rstb_g, w_pop, w_push, w_drop;
    logic [7:0]           w_rdata_g;

    assign w_fall    = r_csn_d & ~bus.sc_csn;
    assign w_rise    = ~r_csn_d & bus.sc_csn;
    assign w_first   = r_first | w_fall;
    // A strobe coinciding with the csn rise still belongs to the closing transaction.
    assign w_stb_ok  = bus.sc_rx_stb & ~(bus.sc_csn & r_csn_d);
    assign w_empty   = r_wp == r_rp;
    assign w_full    = r_wp == {~r_rp[AW], r_rp[AW-1:0]};
    assign w_rstb_g  = |(bus.pw_rstb & r_gnt);
    assign w_rdata_g = bus.pw_rdata[8*r_gidx +: 8];
    assign w_pop     = bus.sc_tx_ack & ~w_empty;
    assign w_drop    = w_rstb_g & w_full & ~w_pop;
    assign w_push    = w_rstb_g & ~w_drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csn_d <= 1'b1;
            r_first <= 1'b0;
            r_wdata <= 8'h00;
            r_wstb  <= 1'b0;
            r_wcmd  <= 1'b0;
            r_end   <= 1'b0;
        end else begin
            r_csn_d <= bus.sc_csn;
            r_first <= w_first & ~w_stb_ok;
            r_wstb  <= w_stb_ok;
            r_wcmd  <= w_stb_ok & w_first;
            r_end   <= w_rise;
            if (w_stb_ok) r_wdata <= bus.sc_rx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_gidx  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_gnt   <= w_gnt_nx;
            r_gidx  <= w_gidx_nx;
        end
    end

    // Grants move only between transactions and only once the FIFO is drained.
    always_comb begin
        w_state_nx = r_state;
        w_gnt_nx   = r_gnt;
        w_gidx_nx  = r_gidx;
        if (r_state == S_IDLE) begin
            if (bus.sc_csn && w_empty && |bus.pw_req) begin
                w_state_nx = S_GRANTED;
                for (int i = N_CLIENTS - 1; i >= 0; i--) begin
                    if (bus.pw_req[i]) begin
                        w_gidx_nx = GW'(i);
                        w_gnt_nx  = N_CLIENTS'(1) << i;
                    end
                end
            end
        end else if (!bus.pw_req[r_gidx] && bus.sc_csn && w_empty) begin
            w_state_nx = S_IDLE;
            w_gnt_nx   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_ovf <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            if (w_push) r_wp <= r_wp + (AW+1)'(1);
            if (w_pop) r_rp <= r_rp + (AW+1)'(1);
            r_ovf <= w_drop | (r_ovf & ~w_fall);
            r_irq <= ~w_empty | |(bus.pw_req & r_gnt);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp[AW-1:0]] <= w_rdata_g;
    end

    assign bus.sc_tx_data = w_empty ? FILL_BYTE : r_mem[r_rp[AW-1:0]];
    assign bus.pw_wdata   = r_wdata;
    assign bus.pw_wcmd    = r_wcmd;
    assign bus.pw_wstb    = r_wstb;
    assign bus.pw_end     = r_end;
    assign bus.pw_gnt     = r_gnt;
    assign bus.tx_ovf     = r_ovf;
    assign bus.irq        = r_irq;
endmodule

// File: tb/tb_spi_proto_wrap.sv
// tb_spi_proto_wrap: directed and random stimulus against a queue-based reference model and scoreboard.
module tb_spi_proto_wrap;
    localparam int         N     = 2;
    localparam int         DEPTH = 16;
    localparam logic [7:0] FILL  = 8'h00;

    typedef struct {
        int         c;
        logic [7:0] d;
        logic       f;
    } wexp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    spi_proto_wrap_if #(.N_CLIENTS(N)) bus ();

    spi_proto_wrap #(.N_CLIENTS(N), .TX_DEPTH(DEPTH), .FILL_BYTE(FILL)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: expected write strobes/ends keyed by cycle, response FIFO as a byte queue.
    wexp_t      wq[$];
    int         endq[$];
    logic [7:0] mq[$];
    logic [N-1:0] mg;
    logic       movf, mirq, mfirst, prevcsn;
    logic       exp_w, exp_e, fall, rise, stb_ok, first, push, pop, drop;
    int         gi, ng;
    wexp_t      e;

    always @(negedge clk) begin
        if (rst) begin
            wq.delete();
            endq.delete();
            mq.delete();
            mg = '0;
            movf = 1'b0;
            mirq = 1'b0;
            mfirst = 1'b0;
            prevcsn = 1'b1;
        end else begin
            exp_w = wq.size() > 0 && wq[0].c == cyc;
            check("pw_wstb", bus.pw_wstb, exp_w);
            if (exp_w) begin
                e = wq.pop_front();
                check("pw_wdata", bus.pw_wdata, e.d);
                check("pw_wcmd", bus.pw_wcmd, e.f);
            end else check("pw_wcmd_idle", bus.pw_wcmd, 0);
            exp_e = endq.size() > 0 && endq[0] == cyc;
            if (exp_e) void'(endq.pop_front());
            check("pw_end", bus.pw_end, exp_e);
            check("pw_gnt", bus.pw_gnt, mg);
            check("tx_ovf", bus.tx_ovf, movf);
            check("irq", bus.irq, mirq);
            if (bus.sc_tx_ack) check("sc_tx_data", bus.sc_tx_data, mq.size() > 0 ? mq[0] : FILL);
            fall   = prevcsn && !bus.sc_csn;
            rise   = !prevcsn && bus.sc_csn;
            stb_ok = bus.sc_rx_stb && !(prevcsn && bus.sc_csn);
            first  = mfirst || fall;
            if (stb_ok) wq.push_back('{cyc + 1, bus.sc_rx_data, first});
            mfirst = first && !stb_ok;
            if (rise) endq.push_back(cyc + 1);
            gi = -1;
            for (int i = 0; i < N; i++) if (mg[i]) gi = i;
            push = gi >= 0 && bus.pw_rstb[gi];
            pop  = bus.sc_tx_ack && mq.size() > 0;
            drop = push && mq.size() == DEPTH && !pop;
            mirq = mq.size() > 0 || (gi >= 0 && bus.pw_req[gi]);
            movf = drop || (movf && !fall);
            if (gi < 0) begin
                if (bus.sc_csn && mq.size() == 0 && bus.pw_req != 0) begin
                    ng = 0;
                    for (int i = N - 1; i >= 0; i--) if (bus.pw_req[i]) ng = i;
                    mg = N'(1) << ng;
                end
            end else if (!bus.pw_req[gi] && bus.sc_csn && mq.size() == 0) mg = '0;
            if (pop) void'(mq.pop_front());
            if (push && !drop) mq.push_back(bus.pw_rdata[8*gi +: 8]);
            prevcsn = bus.sc_csn;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        bus.sc_rx_stb = 1'b0;
        bus.sc_tx_ack = 1'b0;
        bus.pw_rstb   = '0;
    endtask

    task automatic send(input logic [7:0] d);
        bus.sc_rx_data = d;
        bus.sc_rx_stb  = 1'b1;
        step();
    endtask

    task automatic rpush(input int c, input logic [7:0] d);
        bus.pw_rdata[8*c +: 8] = d;
        bus.pw_rstb[c] = 1'b1;
        step();
    endtask

    task automatic read_exp(input logic [7:0] d);
        check("read_byte", bus.sc_tx_data, d);
        bus.sc_tx_ack = 1'b1;
        step();
    endtask

    logic nc;

    initial begin
        bus.sc_csn = 1'b1;
        bus.sc_rx_data = '0;
        bus.sc_rx_stb = 1'b0;
        bus.sc_tx_ack = 1'b0;
        bus.pw_req = '0;
        bus.pw_rdata = '0;
        bus.pw_rstb = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", bus.pw_gnt, 0);
        check("rst_tx_data", bus.sc_tx_data, FILL);
        check("rst_wdata", bus.pw_wdata, 0);
        check("rst_wstb", bus.pw_wstb, 0);
        check("rst_ovf", bus.tx_ovf, 0);
        check("rst_irq", bus.irq, 0);
        rst = 1'b0;
        step();
        step();
        // write stream: cmd on first byte, end after csn rise
        bus.sc_csn = 1'b0;
        step();
        send(8'h10);
        step();
        send(8'hAA);
        send(8'h55);
        bus.sc_csn = 1'b1;
        step();
        step();
        bus.sc_csn = 1'b0;
        step();
        send(8'h01);
        bus.sc_csn = 1'b1;
        send(8'h02);
        bus.sc_csn = 1'b0;
        step();
        send(8'h03);
        bus.sc_csn = 1'b1;
        step();
        step();
        // arbitration and response path
        bus.pw_req = 2'b11;
        step();
        step();
        check("gnt_lowest", bus.pw_gnt, 2'b01);
        bus.sc_csn = 1'b0;
        step();
        bus.pw_rdata = {8'h77, 8'hDE};
        bus.pw_rstb = 2'b11;
        step();
        rpush(0, 8'hAD);
        bus.pw_req = 2'b10;
        step();
        step();
        check("gnt_held", bus.pw_gnt, 2'b01);
        read_exp(8'hDE);
        read_exp(8'hAD);
        read_exp(FILL);
        check("gnt_held_in_txn", bus.pw_gnt, 2'b01);
        bus.sc_csn = 1'b1;
        repeat (3) step();
        check("gnt_next", bus.pw_gnt, 2'b10);
        // overflow and clear on csn fall
        for (int i = 0; i <= DEPTH; i++) rpush(1, 8'(i));
        check("ovf_set", bus.tx_ovf, 1);
        bus.sc_csn = 1'b0;
        step();
        check("ovf_clr", bus.tx_ovf, 0);
        for (int i = 0; i < DEPTH; i++) read_exp(8'(i));
        read_exp(FILL);
        // full with simultaneous push and pop, then pointer wrap
        for (int i = 0; i < DEPTH; i++) rpush(1, 8'h80 + 8'(i));
        check("full_no_ovf", bus.tx_ovf, 0);
        check("full_head", bus.sc_tx_data, 8'h80);
        bus.sc_tx_ack = 1'b1;
        rpush(1, 8'hF0);
        check("full_pushpop_ovf", bus.tx_ovf, 0);
        for (int i = 1; i < DEPTH; i++) read_exp(8'h80 + 8'(i));
        read_exp(8'hF0);
        read_exp(FILL);
        for (int i = 0; i < 3 * DEPTH; i++) begin
            bus.sc_tx_ack = i >= 4 && $urandom_range(0, 3) != 0;
            rpush(1, 8'h20 + 8'(i));
        end
        check("wrap_ovf", bus.tx_ovf, 0);
        repeat (DEPTH + 2) begin
            bus.sc_tx_ack = 1'b1;
            step();
        end
        bus.sc_csn = 1'b1;
        step();
        // async reset mid-transaction with bytes pending
        bus.sc_csn = 1'b0;
        step();
        rpush(1, 8'hC1);
        rpush(1, 8'hC2);
        rpush(1, 8'hC3);
        send(8'h11);
        rst = 1'b1;
        #1;
        check("arst_gnt", bus.pw_gnt, 0);
        check("arst_tx_data", bus.sc_tx_data, FILL);
        check("arst_irq", bus.irq, 0);
        check("arst_wstb", bus.pw_wstb, 0);
        check("arst_wdata", bus.pw_wdata, 0);
        bus.sc_csn = 1'b1;
        step();
        step();
        rst = 1'b0;
        send(8'h22);
        check("stb_csn_high_ignored", bus.pw_wstb, 0);
        bus.sc_csn = 1'b0;
        step();
        send(8'h33);
        check("cmd_after_fresh_fall", bus.pw_wcmd, 1);
        bus.sc_csn = 1'b1;
        step();
        step();
        // random traffic
        for (int n = 0; n < 3000; n++) begin
            nc = bus.sc_csn;
            if ($urandom_range(0, 15) == 0) nc = ~nc;
            bus.sc_rx_stb = !(bus.sc_csn && !nc) && $urandom_range(0, 2) == 0;
            bus.sc_csn = nc;
            bus.sc_rx_data = 8'($urandom);
            bus.sc_tx_ack = $urandom_range(0, 2) == 0;
            if ($urandom_range(0, 15) == 0) bus.pw_req = N'($urandom);
            bus.pw_rstb = N'($urandom) & N'($urandom);
            bus.pw_rdata = 16'($urandom);
            step();
        end
        bus.sc_csn = 1'b1;
        bus.pw_req = '0;
        repeat (DEPTH + 4) begin
            bus.sc_tx_ack = 1'b1;
            step();
        end
        step();
        check("wq_drained", wq.size(), 0);
        check("endq_drained", endq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
